// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter: FSM state encoding,
// operation encoding and the SPI clock divider width.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    localparam int DIV_W = 8;

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester-side and SPI_Master-side signals of the arbiter in one bundle.
// The master modport is the arbiter's view; slave is the requesters plus SPI_Master.
interface spi_master_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*DIV_W-1:0]  cfg_divider;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      busy;

    logic [DIV_W-1:0]          m_sclk_divider;
    logic                      m_wr_en;
    logic                      m_rd_en;
    logic [DATA_W-1:0]         m_tx_wr_data;
    logic                      m_wr_finish;
    logic                      m_rd_finish;
    logic [DATA_W-1:0]         m_rx_rd_data;

    modport master (
        input  req_valid, req_rw, req_wdata, cfg_divider,
        output req_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
        output m_sclk_divider, m_wr_en, m_rd_en, m_tx_wr_data,
        input  m_wr_finish, m_rd_finish, m_rx_rd_data
    );

    modport slave (
        output req_valid, req_rw, req_wdata, cfg_divider,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
        input  m_sclk_divider, m_wr_en, m_rd_en, m_tx_wr_data,
        output m_wr_finish, m_rd_finish, m_rx_rd_data
    );

endinterface

// File: rtl/spi_rr_picker.sv
// Combinational round-robin search: first asserted request starting at ptr,
// then ptr+1, ... wrapping modulo NUM_REQ.
module spi_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] winner
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    off;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
        logic [ID_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end
        return sum[ID_W-1:0];
    endfunction

    // rot[k] is the request k positions after the pointer
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = req[wrap_add(ptr, ID_W'(gi))];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
    end

    assign winner = wrap_add(ptr, off);

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI_Master among NUM_REQ single-byte requesters.
// Define SPI_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC cycles.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    spi_master_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t        state_reg, state_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic              rw_reg, rw_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [DIV_W-1:0]  div_reg, div_next;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic              finish_match;
    logic              timeout_hit;

    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [DIV_W-1:0]  div_arr   [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
            assign div_arr[gi]   = bus.cfg_divider[gi*DIV_W +: DIV_W];
        end
    endgenerate

    spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (bus.req_valid),
        .ptr    (ptr_reg),
        .found  (found),
        .winner (winner)
    );

    // Only the finish of the latched operation ends WAIT
    assign finish_match = (rw_reg == OP_RD) ? bus.m_rd_finish : bus.m_wr_finish;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            rw_reg    <= OP_WR;
            wdata_reg <= '0;
            rdata_reg <= '0;
            div_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            id_reg    <= id_next;
            rw_reg    <= rw_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            div_reg   <= div_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        rw_next    = rw_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        div_next   = div_reg;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    state_next = ST_ISSUE;
                    id_next    = winner;
                    rw_next    = bus.req_rw[winner];
                    wdata_next = wdata_arr[winner];
                    div_next   = div_arr[winner];
                    rdata_next = '0;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (finish_match) begin
                    state_next = ST_DONE;
                    if (rw_reg == OP_RD) begin
                        rdata_next = bus.m_rx_rd_data;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                ptr_next   = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pulses are masked while rst_n is low so nothing leaks out during reset
    assign bus.req_ready      = (rst_n && state_reg == ST_IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
    assign bus.busy           = rst_n && (state_reg != ST_IDLE);
    assign bus.m_wr_en        = rst_n && (state_reg == ST_ISSUE) && (rw_reg == OP_WR);
    assign bus.m_rd_en        = rst_n && (state_reg == ST_ISSUE) && (rw_reg == OP_RD);
    assign bus.m_tx_wr_data   = wdata_reg;
    assign bus.m_sclk_divider = div_reg;
    assign bus.rsp_valid      = rst_n && (state_reg == ST_DONE);
    assign bus.rsp_id         = id_reg;
    assign bus.rsp_rdata      = rdata_reg;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= (state_reg == ST_WAIT) ? cnt_reg + 1'b1 : '0;
            // A finish arriving on the timeout cycle still counts as success
            if (state_reg == ST_WAIT) begin
                err_reg <= timeout_hit && !finish_match;
            end
        end
    end

    assign timeout_hit = (state_reg == ST_WAIT) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
    assign bus.rsp_err = rst_n && (state_reg == ST_DONE) && err_reg;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_hit        = 1'b0;
    assign bus.rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: bench-side SPI_Master responder
// and a round-robin reference model computed with plain modulo arithmetic.
module tb_spi_master_arbiter;

    localparam int NREQ = 4;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ptr_m = 0;

    logic       ref_rw  [NREQ];
    logic [7:0] ref_wd  [NREQ];
    logic [7:0] ref_div [NREQ];

    typedef struct {
        bit         hung;
        logic [3:0] ready;
        int         t_acc;
        int         t_en;
        int         t_fin;
        int         t_rsp;
        logic       wr_en;
        logic       rd_en;
        logic [7:0] tx;
        logic [7:0] div;
        logic [7:0] div_done;
        logic [7:0] rdata;
        logic [1:0] rid;
        logic       err;
        bit         en_long;
        bit         early_rsp;
        bit         busy_drop;
    } obs_t;

    spi_master_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(8)) bus ();

    spi_master_arbiter #(.NUM_REQ(NREQ), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic setreq(input int i, input logic rw, input logic [7:0] wd, input logic [7:0] dv);
        bus.req_valid[i]           = 1'b1;
        bus.req_rw[i]              = rw;
        bus.req_wdata[i*8 +: 8]    = wd;
        bus.cfg_divider[i*8 +: 8]  = dv;
        ref_rw[i]  = rw;
        ref_wd[i]  = wd;
        ref_div[i] = dv;
    endtask

    // Acts as requesters + SPI_Master for one transaction; called at posedge+1.
    // fin_delay < 0 withholds the finish entirely.
    task automatic run_one(input logic [7:0] miso, input int fin_delay, input bit wrong, output obs_t o);
        int   id;
        logic rw;
        bit   got;
        o = '{default: 0};
        got = 0;
        id = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sclk);
            if (bus.req_ready != '0) begin
                got = 1;
                break;
            end
            @(posedge sclk); #1;
        end
        if (!got) begin
            o.hung = 1;
            return;
        end
        o.ready = bus.req_ready;
        o.t_acc = cyc;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) id = i;
        rw = bus.req_rw[id];
        @(posedge sclk); #1;
        bus.req_valid[id] = 1'b0;
        bus.req_wdata[id*8 +: 8]   = 8'($urandom);
        bus.cfg_divider[id*8 +: 8] = 8'($urandom);
        @(negedge sclk);
        o.t_en  = cyc;
        o.wr_en = bus.m_wr_en;
        o.rd_en = bus.m_rd_en;
        o.tx    = bus.m_tx_wr_data;
        o.div   = bus.m_sclk_divider;
        for (int k = 0; k < fin_delay; k++) begin
            @(posedge sclk); #1;
            if (wrong && k == 0) begin
                bus.m_wr_finish  = !rw;
                bus.m_rd_finish  = rw;
                bus.m_wr_finish  = (rw == 1'b1);
                bus.m_rd_finish  = (rw == 1'b0);
                bus.m_rx_rd_data = ~miso;
            end else begin
                bus.m_wr_finish = 1'b0;
                bus.m_rd_finish = 1'b0;
            end
            @(negedge sclk);
            if (bus.m_wr_en || bus.m_rd_en) o.en_long = 1;
            if (bus.rsp_valid) o.early_rsp = 1;
            if (!bus.busy) o.busy_drop = 1;
        end
        @(posedge sclk); #1;
        if (fin_delay >= 0) begin
            bus.m_wr_finish  = (rw == 1'b0);
            bus.m_rd_finish  = (rw == 1'b1);
            bus.m_rx_rd_data = miso;
            @(negedge sclk);
            o.t_fin = cyc;
            if (bus.rsp_valid) o.early_rsp = 1;
            @(posedge sclk); #1;
            bus.m_wr_finish  = 1'b0;
            bus.m_rd_finish  = 1'b0;
            bus.m_rx_rd_data = 8'($urandom);
        end
        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sclk);
            if (bus.rsp_valid) begin
                got = 1;
                break;
            end
            @(posedge sclk); #1;
        end
        if (!got) begin
            o.hung = 1;
            return;
        end
        o.t_rsp    = cyc;
        o.rid      = bus.rsp_id;
        o.rdata    = bus.rsp_rdata;
        o.err      = bus.rsp_err;
        o.div_done = bus.m_sclk_divider;
        @(posedge sclk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        bus.req_valid = 4'(1 + $urandom_range(0, 14));
        @(negedge sclk);
        n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.m_wr_en !== 1'b0 || bus.m_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_en: got wr=%b rd=%b want 0/0", bus.m_wr_en, bus.m_rd_en); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_bad++; $display("FAIL rst_rsp_id: got %0d want 0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", bus.rsp_rdata); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.rsp_err); end
        n_cmp++; if (bus.m_sclk_divider !== 8'h00) begin n_bad++; $display("FAIL rst_div: got %h want 00", bus.m_sclk_divider); end
        n_cmp++; if (bus.m_tx_wr_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx: got %h want 00", bus.m_tx_wr_data); end
        @(posedge sclk); #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge sclk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b want 0", bus.busy); end
        @(posedge sclk); #1;
        $display("txn reset: outputs checked in and after reset");
    endtask

    task automatic test_single_write();
        obs_t o;
        setreq(0, 1'b0, 8'hA5, 8'd4);
        run_one(8'h5A, 3, 0, o);
        n_cmp++; if (o.hung !== 1'b0) begin n_bad++; $display("FAIL wr_hung: got %b want 0", o.hung); end
        n_cmp++; if (o.ready !== 4'b0001) begin n_bad++; $display("FAIL wr_ready: got %b want 0001", o.ready); end
        n_cmp++; if (o.t_en !== o.t_acc + 1) begin n_bad++; $display("FAIL wr_en_lat: got %0d want %0d", o.t_en, o.t_acc + 1); end
        n_cmp++; if (o.wr_en !== 1'b1 || o.rd_en !== 1'b0) begin n_bad++; $display("FAIL wr_en: got wr=%b rd=%b want 1/0", o.wr_en, o.rd_en); end
        n_cmp++; if (o.tx !== 8'hA5) begin n_bad++; $display("FAIL wr_tx: got %h want a5", o.tx); end
        n_cmp++; if (o.div !== 8'd4) begin n_bad++; $display("FAIL wr_div: got %0d want 4", o.div); end
        n_cmp++; if (o.en_long !== 1'b0) begin n_bad++; $display("FAIL wr_en_width: got long=%b want 0", o.en_long); end
        n_cmp++; if (o.t_rsp !== o.t_fin + 1) begin n_bad++; $display("FAIL wr_rsp_lat: got %0d want %0d", o.t_rsp, o.t_fin + 1); end
        n_cmp++; if (o.rid !== 2'd0) begin n_bad++; $display("FAIL wr_rsp_id: got %0d want 0", o.rid); end
        n_cmp++; if (o.rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rdata: got %h want 00", o.rdata); end
        n_cmp++; if (o.err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", o.err); end
        ptr_m = 1;
        $display("txn single_write: id=%0d tx=%h div=%0d rsp_lat=%0d", o.rid, o.tx, o.div, o.t_rsp - o.t_fin);
    endtask

    task automatic test_single_read();
        obs_t o;
        logic [7:0] dv;
        int exp;
        dv = 8'($urandom);
        setreq(2, 1'b1, 8'($urandom), dv);
        exp = pick(bus.req_valid, ptr_m);
        run_one(8'h3C, 4, 0, o);
        n_cmp++; if (o.ready !== 4'(1 << exp)) begin n_bad++; $display("FAIL rd_ready: got %b want %b", o.ready, 4'(1 << exp)); end
        n_cmp++; if (o.rd_en !== 1'b1 || o.wr_en !== 1'b0) begin n_bad++; $display("FAIL rd_en: got wr=%b rd=%b want 0/1", o.wr_en, o.rd_en); end
        n_cmp++; if (o.div !== dv) begin n_bad++; $display("FAIL rd_div: got %h want %h", o.div, dv); end
        n_cmp++; if (o.rid !== 2'(exp)) begin n_bad++; $display("FAIL rd_rsp_id: got %0d want %0d", o.rid, exp); end
        n_cmp++; if (o.rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_rdata: got %h want 3c", o.rdata); end
        n_cmp++; if (o.err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", o.err); end
        n_cmp++; if (o.t_rsp !== o.t_fin + 1) begin n_bad++; $display("FAIL rd_rsp_lat: got %0d want %0d", o.t_rsp, o.t_fin + 1); end
        ptr_m = (exp + 1) % NREQ;
        $display("txn single_read: id=%0d rdata=%h err=%b", o.rid, o.rdata, o.err);
    endtask

    task automatic test_round_robin();
        obs_t o;
        logic [7:0] miso;
        int exp;
        rst_n = 1'b0;
        @(posedge sclk); #1;
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < NREQ; i++) setreq(i, 1'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 8; k++) begin
            miso = 8'($urandom);
            exp = pick(bus.req_valid, ptr_m);
            run_one(miso, $urandom_range(1, 5), 0, o);
            n_cmp++; if (o.ready !== 4'(1 << (k % NREQ))) begin n_bad++; $display("FAIL rr_order[%0d]: got %b want %b", k, o.ready, 4'(1 << (k % NREQ))); end
            n_cmp++; if ((o.wr_en ^ o.rd_en) !== 1'b1 || o.rd_en !== ref_rw[exp]) begin n_bad++; $display("FAIL rr_en[%0d]: got wr=%b rd=%b want rd=%b only", k, o.wr_en, o.rd_en, ref_rw[exp]); end
            n_cmp++; if (o.tx !== ref_wd[exp]) begin n_bad++; $display("FAIL rr_tx[%0d]: got %h want %h", k, o.tx, ref_wd[exp]); end
            n_cmp++; if (o.div_done !== ref_div[exp]) begin n_bad++; $display("FAIL rr_div[%0d]: got %h want %h", k, o.div_done, ref_div[exp]); end
            n_cmp++; if (o.rdata !== (ref_rw[exp] ? miso : 8'h00)) begin n_bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, o.rdata, ref_rw[exp] ? miso : 8'h00); end
            n_cmp++; if (o.rid !== 2'(exp)) begin n_bad++; $display("FAIL rr_rsp_id[%0d]: got %0d want %0d", k, o.rid, exp); end
            $display("txn round_robin[%0d]: grant=%b rw=%b tx=%h div=%h rdata=%h", k, o.ready, o.rd_en, o.tx, o.div_done, o.rdata);
            ptr_m = (exp + 1) % NREQ;
            setreq(exp, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        bus.req_valid = '0;
    endtask

    task automatic test_wrong_finish();
        obs_t o;
        logic [7:0] miso;
        int r;
        int exp;
        for (int rw = 0; rw < 2; rw++) begin
            r = $urandom_range(0, NREQ - 1);
            miso = 8'($urandom);
            setreq(r, 1'(rw), 8'($urandom), 8'($urandom));
            exp = pick(bus.req_valid, ptr_m);
            run_one(miso, 3, 1, o);
            n_cmp++; if (o.early_rsp !== 1'b0) begin n_bad++; $display("FAIL wf_early_rsp[rw=%0d]: got %b want 0", rw, o.early_rsp); end
            n_cmp++; if (o.busy_drop !== 1'b0) begin n_bad++; $display("FAIL wf_busy[rw=%0d]: got drop=%b want 0", rw, o.busy_drop); end
            n_cmp++; if (o.t_rsp !== o.t_fin + 1) begin n_bad++; $display("FAIL wf_rsp_lat[rw=%0d]: got %0d want %0d", rw, o.t_rsp, o.t_fin + 1); end
            n_cmp++; if (o.rdata !== (rw == 1 ? miso : 8'h00)) begin n_bad++; $display("FAIL wf_rdata[rw=%0d]: got %h want %h", rw, o.rdata, rw == 1 ? miso : 8'h00); end
            n_cmp++; if (o.rid !== 2'(exp)) begin n_bad++; $display("FAIL wf_rsp_id[rw=%0d]: got %0d want %0d", rw, o.rid, exp); end
            ptr_m = (exp + 1) % NREQ;
            $display("txn wrong_finish: rw=%0d id=%0d rdata=%h", rw, o.rid, o.rdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        bit got;
        bit bad_rsp;
        int exp;
        got = 0;
        bad_rsp = 0;
        setreq(2, 1'b1, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 20; k++) begin
            @(negedge sclk);
            if (bus.req_ready[2]) begin
                got = 1;
                break;
            end
            @(posedge sclk); #1;
        end
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rmw_accept: got %b want 1", got); end
        @(posedge sclk); #1;
        bus.req_valid[2] = 1'b0;
        repeat (3) begin
            @(negedge sclk);
            if (bus.rsp_valid) bad_rsp = 1;
            @(posedge sclk); #1;
        end
        @(negedge sclk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rmw_in_wait: got busy=%b want 1", bus.busy); end
        @(posedge sclk); #1;
        rst_n = 1'b0;
        bus.m_rd_finish  = 1'b1;
        bus.m_rx_rd_data = 8'h99;
        @(negedge sclk);
        if (bus.rsp_valid) bad_rsp = 1;
        @(posedge sclk); #1;
        rst_n = 1'b1;
        bus.m_rd_finish = 1'b0;
        ptr_m = 0;
        @(negedge sclk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmw_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.m_rd_en !== 1'b0 || bus.m_wr_en !== 1'b0) begin n_bad++; $display("FAIL rmw_en: got wr=%b rd=%b want 0/0", bus.m_wr_en, bus.m_rd_en); end
        repeat (3) begin
            if (bus.rsp_valid) bad_rsp = 1;
            @(posedge sclk); #1;
            @(negedge sclk);
        end
        n_cmp++; if (bad_rsp !== 1'b0) begin n_bad++; $display("FAIL rmw_no_rsp: got rsp seen=%b want 0", bad_rsp); end
        @(posedge sclk); #1;
        setreq(3, 1'($urandom), 8'($urandom), 8'($urandom));
        setreq(1, 1'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 2; k++) begin
            exp = pick(bus.req_valid, ptr_m);
            run_one(8'($urandom), 2, 0, o);
            n_cmp++; if (o.ready !== 4'(1 << exp)) begin n_bad++; $display("FAIL rmw_grant[%0d]: got %b want %b", k, o.ready, 4'(1 << exp)); end
            n_cmp++; if (o.rid !== 2'(exp)) begin n_bad++; $display("FAIL rmw_rsp_id[%0d]: got %0d want %0d", k, o.rid, exp); end
            ptr_m = (exp + 1) % NREQ;
            $display("txn after_reset[%0d]: grant=%b id=%0d", k, o.ready, o.rid);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [7:0] miso;
        int exp;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) setreq(i, 1'($urandom), 8'($urandom), 8'($urandom));
                else if (bus.req_valid[i] && $urandom_range(0, 4) == 0) bus.req_valid[i] = 1'b0;
            end
            if (bus.req_valid == '0) setreq($urandom_range(0, NREQ - 1), 1'($urandom), 8'($urandom), 8'($urandom));
            miso = 8'($urandom);
            exp = pick(bus.req_valid, ptr_m);
            run_one(miso, $urandom_range(0, 6), 0, o);
            n_cmp++; if (o.ready !== 4'(1 << exp)) begin n_bad++; $display("FAIL rnd_grant[%0d]: got %b want %b", k, o.ready, 4'(1 << exp)); end
            n_cmp++; if (o.rd_en !== ref_rw[exp] || o.wr_en !== !ref_rw[exp]) begin n_bad++; $display("FAIL rnd_en[%0d]: got wr=%b rd=%b want rd=%b", k, o.wr_en, o.rd_en, ref_rw[exp]); end
            n_cmp++; if (o.tx !== ref_wd[exp] || o.div !== ref_div[exp]) begin n_bad++; $display("FAIL rnd_data[%0d]: got tx=%h div=%h want %h/%h", k, o.tx, o.div, ref_wd[exp], ref_div[exp]); end
            n_cmp++; if (o.rdata !== (ref_rw[exp] ? miso : 8'h00) || o.err !== 1'b0) begin n_bad++; $display("FAIL rnd_rsp[%0d]: got rdata=%h err=%b want %h/0", k, o.rdata, o.err, ref_rw[exp] ? miso : 8'h00); end
            n_cmp++; if (o.t_en !== o.t_acc + 1 || o.rid !== 2'(exp)) begin n_bad++; $display("FAIL rnd_lat_id[%0d]: got en_lat=%0d id=%0d want 1/%0d", k, o.t_en - o.t_acc, o.rid, exp); end
            ptr_m = (exp + 1) % NREQ;
            $display("txn random[%0d]: grant=%b rw=%b tx=%h rdata=%h", k, o.ready, o.rd_en, o.tx, o.rdata);
        end
        bus.req_valid = '0;
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        int exp;
        setreq(0, 1'b1, 8'($urandom), 8'($urandom));
        exp = pick(bus.req_valid, ptr_m);
        run_one(8'h77, -1, 0, o);
        n_cmp++; if (o.hung !== 1'b0) begin n_bad++; $display("FAIL to_hung: got %b want 0", o.hung); end
        n_cmp++; if (o.err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", o.err); end
        n_cmp++; if (o.rdata !== 8'h00) begin n_bad++; $display("FAIL to_rdata: got %h want 00", o.rdata); end
        n_cmp++; if (o.t_rsp !== o.t_en + 17) begin n_bad++; $display("FAIL to_lat: got %0d want %0d", o.t_rsp, o.t_en + 17); end
        n_cmp++; if (o.rid !== 2'(exp)) begin n_bad++; $display("FAIL to_rsp_id: got %0d want %0d", o.rid, exp); end
        ptr_m = (exp + 1) % NREQ;
        $display("txn timeout: id=%0d err=%b wait_cycles=%0d", o.rid, o.err, o.t_rsp - o.t_en - 1);
    endtask
`endif

    initial begin
        bus.req_valid    = '0;
        bus.req_rw       = '0;
        bus.req_wdata    = '0;
        bus.cfg_divider  = '0;
        bus.m_wr_finish  = 1'b0;
        bus.m_rd_finish  = 1'b0;
        bus.m_rx_rd_data = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_wrong_finish();
        test_reset_mid_wait();
        test_random();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one SPI_Master instance between NUM_REQ on-chip requesters, each issuing single-byte write or read transactions.
- Arbitrates round-robin and drives the master's wr_en/rd_en pulses, tx_wr_data and per-requester sclk_divider.
- Waits for wr_finish/rd_finish, then returns read data and completion to the granted requester.
- Sits between requester logic and SPI_Master; SPI_SCLK, SPI_CSN, SPI_MOSI and SPI_MISO stay on the master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, transaction data width; matches SPI_Master tx/rx width.
- TIMEOUT_CYC, 4096, sclk cycles allowed in WAIT before abort (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- sclk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_rw  in  NUM_REQ  per-requester op: 1 = read, 0 = write.
- req_wdata  in  NUM_REQ*DATA_W  per-requester write byte; slice i belongs to requester i.
- cfg_divider  in  NUM_REQ*8  per-requester SPI clock divider.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  $clog2(NUM_REQ)  requester index for rsp_valid.
- rsp_rdata  out  DATA_W  read byte; 0 for writes.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- m_sclk_divider  out  8  to SPI_Master sclk_divider.
- m_wr_en  out  1  to SPI_Master wr_en.
- m_rd_en  out  1  to SPI_Master rd_en.
- m_tx_wr_data  out  DATA_W  to SPI_Master tx_wr_data.
- m_wr_finish  in  1  from SPI_Master.
- m_rd_finish  in  1  from SPI_Master.
- m_rx_rd_data  in  DATA_W  from SPI_Master.

Behaviour:
- Reset (sync, rst_n=0 at a sclk edge):
  - State IDLE; round-robin pointer = 0.
  - All outputs 0, including m_sclk_divider, rsp_id and the latched id/rw/data registers.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req_valid, pick the first valid index searching pointer, pointer+1, ... with wrap mod NUM_REQ.
  - Latch id, rw, wdata and divider of the winner; pulse req_ready[id] in the same cycle; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - One-cycle pulse on m_rd_en (rw=1) or m_wr_en (rw=0); never both.
  - m_tx_wr_data and m_sclk_divider are registered and stable from ISSUE through DONE.
  - Go to WAIT.
- WAIT:
  - Leave only on the matching finish: m_wr_finish for writes, m_rd_finish for reads. The non-matching finish is ignored.
  - On a read finish, capture m_rx_rd_data in that cycle.
  - Go to DONE.
- DONE:
  - rsp_valid=1 for one cycle, with rsp_id, rsp_rdata and rsp_err.
  - pointer = (id+1) mod NUM_REQ; go to IDLE.
- Latency:
  - Accept at cycle T, enable pulse at T+1.
  - Finish seen at F gives rsp_valid at F+1.
  - Next accept no earlier than F+2.
- Handshake:
  - A requester holds req_valid and its data until it sees req_ready.
  - Deasserting req_valid before grant is legal and yields no transaction.
  - req_valid sampled high in the req_ready cycle is not a new request.
- Simultaneous requests: only one grant per IDLE visit. The pointer rotation gives each requester service within NUM_REQ transactions.
- Data rules:
  - A divider latched at accept is not changed by later cfg_divider changes.
  - rsp_rdata = 0 on writes.
- Reset mid-transaction: return to IDLE, drop enables, produce no rsp_valid. SPI_Master shares rst_n.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT and clears on entry.
  - When it reaches TIMEOUT_CYC-1 without a matching finish, go to DONE with rsp_err=1 and rsp_rdata=0.
  - A finish in the same cycle as the timeout wins: rsp_err=0.
- Undefined: no counter is built, rsp_err is tied 0, and WAIT is unbounded.

Decomposition:
- spi_arb_pkg:
  - State encoding localparams ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_DONE=3.
  - Op encoding OP_WR=0, OP_RD=1.
  - Default divider width 8.
- Sub-module spi_rr_picker: combinational round-robin search.
  - Inputs: req vector and pointer.
  - Outputs: found flag and winner index.
  - Kept separate so it can be unit-tested.

Test Plan:
- Single write: req_valid[0]=1, rw=0, wdata=8'hA5, divider=4.
  - Expected: req_ready[0] at T, m_wr_en at T+1, m_tx_wr_data=A5, m_sclk_divider=4.
  - Expected: rsp_valid with id 0, rdata 0 one cycle after m_wr_finish.
- Single read: requester 2, MISO pattern returns 8'h3C.
  - Expected: m_rd_en pulse, then rsp_valid with id 2, rsp_rdata=3C, rsp_err=0.
- Round-robin: all 4 requesters hold req_valid, 8 transactions.
  - Expected grant order: 0,1,2,3,0,1,2,3.
  - Expected: only one of m_wr_en/m_rd_en per transaction.
- Wrong finish ignored: read in flight, inject m_wr_finish.
  - Expected: stays in WAIT, no rsp_valid until m_rd_finish.
- Reset mid-WAIT: rst_n=0 for 1 cycle during a read.
  - Expected: busy=0, no rsp_valid, pointer=0.
  - Expected: next request from requester 3 is granted normally.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): suppress finish.
  - Expected: rsp_valid with rsp_err=1, rsp_rdata=0 exactly 16 cycles after WAIT entry.
